nes_pad_reader: RTL
===================

// Module: nes_pad_reader
// PURPOSE
//  Self-timed serial reader for NUM_PADS NES/SNES-style shift-register pads sharing one latch and one clock line.
//  Generates latch/clock pulses from internal timers (no external counters), samples all data lines in parallel,
//  and presents a registered, active-high button word per pad. Sits between the pad I/O pins and game logic (paddles).
// PARAMETERS
//  NUM_PADS      2       number of pads read in parallel (>=1)
//  NUM_BITS      8       bits shifted per pad (8 = NES, 16 = SNES) (>=1)
//  LATCH_CYCLES  300     nes_latch high time in clk cycles (12 us @ 25 MHz) (>=1)
//  HALF_PERIOD   150     nes_clk low time = high time in clk cycles (6 us @ 25 MHz) (>=3)
//  POLL_PERIOD   420000  auto-poll interval in clk cycles (~60 Hz); used only with NES_AUTO_POLL_EN
// PORTS
//  clk       in   1                  system clock
//  reset     in   1                  asynchronous, active-high reset
//  poll_req  in   1                  start one read; honoured only in IDLE
//  nes_data  in   NUM_PADS           serial data per pad, active-low (0 = pressed), asynchronous
//  nes_latch out  1                  shared latch strobe to all pads
//  nes_clk   out  1                  shared shift clock to all pads; idles low
//  buttons   out  NUM_PADS*NUM_BITS  buttons[p*NUM_BITS+k] = bit k of pad p, 1 = pressed; k=0 first shifted (A)
//  valid     out  1                  one-cycle strobe, buttons updated
//  busy      out  1                  high in every state except IDLE
// BEHAVIOUR
//  - Reset (async): state IDLE, nes_latch=0, nes_clk=0, buttons=0, valid=0, busy=0, timers/bit index=0, sync flops=1.
//  - nes_data passes a 2-flop synchronizer per pad; all sampling uses the synchronized value.
//  - States: IDLE -> LATCH -> READ_LO -> READ_HI -> (READ_LO | DONE) -> IDLE.
//    IDLE:    outputs low; poll_req=1 -> LATCH, timer loaded LATCH_CYCLES, bit index 0.
//    LATCH:   nes_latch=1 for exactly LATCH_CYCLES cycles -> READ_LO.
//    READ_LO: nes_clk=0 for HALF_PERIOD cycles; in its last cycle shift_reg[p][idx] <= ~sync(nes_data[p]) -> READ_HI.
//    READ_HI: nes_clk=1 for HALF_PERIOD cycles; at end idx==NUM_BITS-1 -> DONE, else idx+1 -> READ_LO.
//    DONE:    1 cycle; buttons <= shift_reg (all pads at once), valid=1 this cycle only -> IDLE.
//  - Exactly NUM_BITS nes_clk pulses per read (trailing pulse after last bit included).
//  - Latency: poll_req sampled at edge 0 -> valid high in cycle starting edge 1+LATCH_CYCLES+2*HALF_PERIOD*NUM_BITS.
//  - buttons holds last complete frame between reads; partial frames never visible.
//  - poll_req while busy: ignored, not queued. poll_req held high: back-to-back reads, one IDLE cycle between.
//  - Reset mid-read: immediate return to reset values; nes_latch/nes_clk drop asynchronously; frame discarded.
//  - Widths: timer $clog2(max(LATCH_CYCLES,HALF_PERIOD)+1), bit index $clog2(NUM_BITS+1); no wrap beyond terminal.
// CONFIGURATION
//  NES_AUTO_POLL_EN defined: free-running counter 0..POLL_PERIOD-1 (reset 0); at terminal count a request is
//   ORed with poll_req; if busy then, that request is dropped (counter still wraps).
//  NES_AUTO_POLL_EN undefined: no poll counter; reads start only from poll_req.
// STRUCTURE
//  - Package nes_pkg: state encoding localparams (IDLE..DONE), NES bit indices BTN_A=0,BTN_B=1,BTN_SELECT=2,
//    BTN_START=3,BTN_UP=4,BTN_DOWN=5,BTN_LEFT=6,BTN_RIGHT=7.
//  - Sub-module nes_phase_timer: load value + down-count, 'last' flag on final cycle; one instance shared by all
//    phases. FSM, synchronizers, shift registers and output registers in this module.
// TESTING (NUM_PADS=2, NUM_BITS=8, LATCH_CYCLES=8, HALF_PERIOD=4 unless stated)
//  1. Assert reset with random inputs -> nes_latch=0, nes_clk=0, buttons=16'h0000, valid=0, busy=0.
//  2. Pad models press 8'h5A (pad0), 8'h81 (pad1); pulse poll_req -> latch high 8 cycles, 8 clk pulses 4/4,
//     valid one cycle at edge 73, buttons=16'h815A.
//  3. Re-pulse poll_req at cycles 10 and 40 of a read -> only one latch pulse, one valid.
//  4. Assert reset after 3rd nes_clk pulse -> nes_latch/nes_clk low at once, buttons=0; next poll returns 16'h815A.
//  5. NUM_BITS=16, pad0 presses 16'hBEEF -> 16 clk pulses, buttons[15:0]=16'hBEEF, valid at edge 137.
//  6. NES_AUTO_POLL_EN, POLL_PERIOD=200, poll_req=0 -> valid every 200 cycles, buttons track pad model changes.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared definitions for the NES/SNES pad reader: FSM state encoding and NES button bit positions.
package nes_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LATCH   = 3'd1;
  localparam logic [2:0] S_READ_LO = 3'd2;
  localparam logic [2:0] S_READ_HI = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = S_IDLE,
    LATCH   = S_LATCH,
    READ_LO = S_READ_LO,
    READ_HI = S_READ_HI,
    DONE    = S_DONE
  } nes_state_e;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nes_phase_timer.sv
// Loadable down-counter shared by all reader phases; 'last' marks the final cycle of a loaded interval.
module nes_phase_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] cnt_q, cnt_d;

  // Parks at zero once expired so an idle reader never sees a spurious 'last'.
  always_comb begin
    cnt_d = cnt_q;
    if (load)               cnt_d = load_val;
    else if (cnt_q != '0)   cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign last = (cnt_q == W'(1));

endmodule

// File: rtl/nes_pad_reader.sv
// Self-timed parallel reader for NUM_PADS shift-register game pads on a shared latch/clock pair.
// Optional build macro NES_AUTO_POLL_EN adds a free-running poll timer (period POLL_PERIOD).
module nes_pad_reader
  import nes_pkg::*;
#(
  parameter int NUM_PADS     = 2,
  parameter int NUM_BITS     = 8,
  parameter int LATCH_CYCLES = 300,
  parameter int HALF_PERIOD  = 150,
  parameter int POLL_PERIOD  = 420000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         poll_req,
  input  logic [NUM_PADS-1:0]          nes_data,
  output logic                         nes_latch,
  output logic                         nes_clk,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons,
  output logic                         valid,
  output logic                         busy
);

  localparam int TW = $clog2(max2(LATCH_CYCLES, HALF_PERIOD) + 1);
  localparam int IW = $clog2(NUM_BITS + 1);

  nes_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NUM_PADS-1:0] sync1_q, sync2_q;
  logic [NUM_PADS-1:0][NUM_BITS-1:0] shift_q, shift_d, buttons_q, buttons_d;
  logic valid_q, valid_d;
  logic t_load, t_last;
  logic [TW-1:0] t_val;
  logic start_req;

`ifdef NES_AUTO_POLL_EN
  localparam int PW = $clog2(POLL_PERIOD + 1);
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic auto_req;

  // Terminal-count request is simply dropped if a read is still running.
  always_comb begin
    auto_req   = (poll_cnt_q == PW'(POLL_PERIOD - 1));
    poll_cnt_d = auto_req ? '0 : poll_cnt_q + PW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) poll_cnt_q <= '0;
    else       poll_cnt_q <= poll_cnt_d;
  end

  assign start_req = poll_req | auto_req;
`else
  assign start_req = poll_req;
`endif

  nes_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .last     (t_last)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    valid_d   = 1'b0;
    t_load    = 1'b0;
    t_val     = '0;
    case (state_q)
      IDLE: if (start_req) begin
        state_d = LATCH;
        idx_d   = '0;
        t_load  = 1'b1;
        t_val   = TW'(LATCH_CYCLES);
      end
      LATCH: if (t_last) begin
        state_d = READ_LO;
        t_load  = 1'b1;
        t_val   = TW'(HALF_PERIOD);
      end
      // Sample as late as possible in the low phase so pad data has fully settled.
      READ_LO: if (t_last) begin
        for (int p = 0; p < NUM_PADS; p++)
          for (int k = 0; k < NUM_BITS; k++)
            if (idx_q == IW'(k)) shift_d[p][k] = ~sync2_q[p];
        state_d = READ_HI;
        t_load  = 1'b1;
        t_val   = TW'(HALF_PERIOD);
      end
      READ_HI: if (t_last) begin
        if (idx_q == IW'(NUM_BITS - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = READ_LO;
          t_load  = 1'b1;
          t_val   = TW'(HALF_PERIOD);
        end
      end
      DONE: begin
        buttons_d = shift_q;
        valid_d   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      sync1_q   <= '1;
      sync2_q   <= '1;
      shift_q   <= '0;
      buttons_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sync1_q   <= nes_data;
      sync2_q   <= sync1_q;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      valid_q   <= valid_d;
    end
  end

  // Pin strobes decode straight from the state flop so reset drops them immediately.
  assign nes_latch = (state_q == LATCH);
  assign nes_clk   = (state_q == READ_HI);
  assign busy      = (state_q != IDLE);
  assign valid     = valid_q;
  assign buttons   = buttons_q;

endmodule
